// File: rtl/chorus_tap_reader.sv
`default_nettype none
// ============================================================================
// Module   : chorus_tap_reader
// Purpose  : Chorus delay-line read controller. Optional fractional-delay
//            interpolation is enabled with `define CHORUS_INTERP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chorus_tap_reader #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 16,
    parameter int BASE_DELAY = 1024,
    parameter int DEPTH_MAX  = 512,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 sample_valid,
    input  logic [MEM_DEPTH-1:0] wr_addr,
    input  logic [15:0]          lfo_step,
    input  logic [MEM_DEPTH-1:0] mod_depth,
    output logic [MEM_DEPTH-1:0] addrb,
    input  logic [MEM_WIDTH-1:0] doutb,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int c_dly_w  = MEM_DEPTH + 2;
    localparam int c_prod_w = MEM_DEPTH + 15;
`ifdef CHORUS_INTERP_EN
    localparam int c_wait_last = RD_LATENCY;
`else
    localparam int c_wait_last = RD_LATENCY - 1;
`endif
    localparam int c_cnt_w = (c_wait_last < 1) ? 1 : $clog2(c_wait_last + 1);

    localparam logic [c_dly_w-1:0]   c_base      = c_dly_w'(BASE_DELAY);
    localparam logic [MEM_DEPTH-1:0] c_depth_max = MEM_DEPTH'(DEPTH_MAX);
    localparam logic [c_cnt_w-1:0]   c_cnt_last  = c_cnt_w'(c_wait_last);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [MEM_DEPTH-1:0] addrb_q, addrb_d;
    logic [MEM_DEPTH-1:0] fill_q, fill_d;
    logic [MEM_WIDTH-1:0] dout_q, dout_d;
    logic [15:0]          phase_q, phase_d;
    logic [c_cnt_w-1:0]   wcnt_q, wcnt_d;
    logic                 overrun_q, overrun_d;
    logic                 zero_q, zero_d;

    logic [14:0]          w_tri;
    logic [MEM_DEPTH-1:0] w_md;
    logic [MEM_DEPTH-1:0] w_ip;
    logic [c_prod_w-1:0]  w_prod;
    logic [c_dly_w-1:0]   w_delay;
    logic [c_dly_w-1:0]   w_warm;
    logic [MEM_DEPTH-1:0] w_addr;
    logic [MEM_WIDTH-1:0] w_wet;

    assign w_tri   = phase_q[15] ? ~phase_q[14:0] : phase_q[14:0];
    assign w_md    = (mod_depth > c_depth_max) ? c_depth_max : mod_depth;
    assign w_prod  = c_prod_w'(w_tri) * c_prod_w'(w_md);
    assign w_ip    = MEM_DEPTH'(w_prod >> 15);
    assign w_delay = c_base + c_dly_w'(w_ip);
    // Extra headroom bits keep the subtraction honest; the truncation is the modular wrap.
    assign w_addr  = MEM_DEPTH'({2'b00, wr_addr} - w_delay);

`ifdef CHORUS_INTERP_EN
    localparam int c_ext_w = MEM_WIDTH + 9;

    logic [7:0]                  frac_q, frac_d;
    logic signed [MEM_WIDTH-1:0] s0_q, s0_d;
    logic signed [c_ext_w-1:0]   w_s0x, w_s1x, w_step;

    // The second tap is one sample older, so warm-up needs one more stored sample.
    assign w_warm = w_delay + c_dly_w'(1);
    assign w_s0x  = c_ext_w'(s0_q);
    assign w_s1x  = c_ext_w'($signed(doutb));
    assign w_step = (w_s1x - w_s0x) * c_ext_w'($signed({1'b0, frac_q}));
    assign w_wet  = MEM_WIDTH'(w_s0x + (w_step >>> 8));
`else
    assign w_warm = w_delay;
    assign w_wet  = doutb;
`endif

    always_comb begin
        state_d   = state_q;
        addrb_d   = addrb_q;
        fill_d    = fill_q;
        dout_d    = dout_q;
        phase_d   = phase_q;
        wcnt_d    = wcnt_q;
        zero_d    = zero_q;
        overrun_d = overrun_q | (sample_valid && (state_q != S_IDLE));
`ifdef CHORUS_INTERP_EN
        frac_d    = frac_q;
        s0_d      = s0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    addrb_d = w_addr;
                    phase_d = phase_q + lfo_step;
                    fill_d  = (&fill_q) ? fill_q : fill_q + MEM_DEPTH'(1);
                    zero_d  = ({2'b00, fill_q} < w_warm);
`ifdef CHORUS_INTERP_EN
                    frac_d  = 8'(w_prod >> 7);
`endif
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                wcnt_d  = '0;
`ifdef CHORUS_INTERP_EN
                addrb_d = addrb_q - MEM_DEPTH'(1);
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef CHORUS_INTERP_EN
                if (wcnt_q == c_cnt_w'(RD_LATENCY - 1)) begin
                    s0_d = $signed(doutb);
                end
`endif
                if (wcnt_q == c_cnt_last) begin
                    dout_d  = zero_q ? '0 : w_wet;
                    state_d = S_OUT;
                end else begin
                    wcnt_d = wcnt_q + c_cnt_w'(1);
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addrb_q   <= '0;
            fill_q    <= '0;
            dout_q    <= '0;
            phase_q   <= '0;
            wcnt_q    <= '0;
            zero_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef CHORUS_INTERP_EN
            frac_q    <= '0;
            s0_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addrb_q   <= addrb_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            phase_q   <= phase_d;
            wcnt_q    <= wcnt_d;
            zero_q    <= zero_d;
            overrun_q <= overrun_d;
`ifdef CHORUS_INTERP_EN
            frac_q    <= frac_d;
            s0_q      <= s0_d;
`endif
        end
    end

    assign addrb      = addrb_q;
    assign dout       = dout_q;
    assign dout_valid = (state_q == S_OUT);
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_chorus_tap_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_chorus_tap_reader
// Purpose  : Directed, table-driven self-checking bench for chorus_tap_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chorus_tap_reader;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] lfo_step = '0;
    logic [15:0] mod_depth = '0;
    logic [15:0] addrb;
    logic [15:0] doutb = '0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        overrun;
    logic [15:0] ram_p1 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    chorus_tap_reader dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .wr_addr      (wr_addr),
        .lfo_step     (lfo_step),
        .mod_depth    (mod_depth),
        .addrb        (addrb),
        .doutb        (doutb),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Two-cycle registered read port model
    always @(posedge clk) begin
        ram_p1 <= ram_word(addrb);
        doutb  <= ram_p1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_sample(input string name, input logic [15:0] wa, input logic [15:0] md,
                             input logic [15:0] step, input logic [15:0] exp_addr,
                             input bit exp_zero, input bit chk);
        int lat;
        bit got;
        @(negedge clk);
        sample_valid = 1'b1;
        wr_addr      = wa;
        mod_depth    = md;
        lfo_step     = step;
        @(negedge clk);
        sample_valid = 1'b0;
        if (chk) begin
            check({name, ".addrb"}, 32'(addrb), 32'(exp_addr));
            check({name, ".busy1"}, 32'(busy), 32'd1);
        end
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (dout_valid) got = 1'b1;
        end
        check({name, ".valid"}, 32'(got), 32'd1);
        if (got && chk) begin
            check({name, ".latency"}, 32'(lat), 32'd4);
            check({name, ".dout"}, 32'(dout), exp_zero ? 32'd0 : 32'(ram_word(exp_addr)));
            check({name, ".busy_out"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        if (chk) begin
            check({name, ".pulse"}, 32'(dout_valid), 32'd0);
            check({name, ".idle"}, 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] wa;
        logic [15:0] md;
        logic [15:0] step;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int  lat;
        bit  got;
        bit  seen;

        vecs[0]  = '{16'd5000, 16'd0,      16'h0000, 16'd3976};
        vecs[1]  = '{16'd100,  16'd0,      16'h0000, 16'd64612};
        vecs[2]  = '{16'd0,    16'd0,      16'h0000, 16'd64512};
        vecs[3]  = '{16'd5000, 16'd1000,   16'h4000, 16'd3976};
        vecs[4]  = '{16'd5000, 16'd1000,   16'h4000, 16'd3720};
        vecs[5]  = '{16'd5000, 16'd1000,   16'h4000, 16'd3465};
        vecs[6]  = '{16'd5000, 16'd1000,   16'h4000, 16'd3721};
        vecs[7]  = '{16'd5000, 16'd300,    16'h2000, 16'd3976};
        vecs[8]  = '{16'd5000, 16'd300,    16'h2000, 16'd3901};
        vecs[9]  = '{16'd5000, 16'd512,    16'h0000, 16'd3720};
        vecs[10] = '{16'd1000, 16'hFFFF,   16'h0000, 16'd65256};

        // Reset and idle state
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.addrb", 32'(addrb), 32'd0);
        check("rst.dout", 32'(dout), 32'd0);
        check("rst.dout_valid", 32'(dout_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);

        // Warm-up: first 1024 samples read as silence, then RAM data; prime fill to 2000
        for (int i = 1; i <= 2000; i++) begin
            do_sample($sformatf("warm%0d", i), 16'd1500, (i == 1) ? 16'd1000 : 16'd0,
                      16'h0000, 16'd476, (i <= 1024),
                      (i <= 3) || (i == 1024) || (i == 1025));
        end

        // Address wrap and LFO modulation vectors
        for (int i = 0; i < 11; i++) begin
            do_sample($sformatf("vec%0d", i), vecs[i].wa, vecs[i].md, vecs[i].step,
                      vecs[i].exp_addr, 1'b0, 1'b1);
        end
        check("pre_ovr.overrun", 32'(overrun), 32'd0);

        // Back-to-back strobes: second is dropped, phase must not advance for it
        @(negedge clk);
        sample_valid = 1'b1;
        wr_addr      = 16'd5000;
        mod_depth    = 16'd1000;
        lfo_step     = 16'h4000;
        @(negedge clk);
        wr_addr = 16'd6000;
        check("ovr.addrb", 32'(addrb), 32'd3720);
        @(negedge clk);
        sample_valid = 1'b0;
        check("ovr.flag", 32'(overrun), 32'd1);
        lat = 2;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (dout_valid) got = 1'b1;
        end
        check("ovr.valid", 32'(got), 32'd1);
        check("ovr.latency", 32'(lat), 32'd4);
        check("ovr.dout", 32'(dout), 32'(ram_word(16'd3720)));
        @(negedge clk);
        check("ovr.single", 32'(dout_valid), 32'd0);
        do_sample("post_ovr", 16'd5000, 16'd1000, 16'h0000, 16'd3465, 1'b0, 1'b1);
        check("post_ovr.sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a read abandons it
        @(negedge clk);
        sample_valid = 1'b1;
        wr_addr      = 16'd5000;
        mod_depth    = 16'd0;
        lfo_step     = 16'h0000;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.addrb", 32'(addrb), 32'd0);
        check("midrst.overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dout_valid) seen = 1'b1;
        end
        check("midrst.no_valid", 32'(seen), 32'd0);
        check("midrst.dout", 32'(dout), 32'd0);
        do_sample("post_rst", 16'd1500, 16'd1000, 16'h0000, 16'd476, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
